// File: rtl/spw_buffer_ctrl.sv
// In-order valid/ready controller driving the spw_buffer write/read ports, with a flush FSM.
// Optional SPW_BUFFER_CTRL_OUT_REG_EN adds a one-entry output register in front of out_*.
module spw_buffer_ctrl #(
    parameter int PTR_WIDTH  = 3,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    input  logic                  flush_i,
    output logic                  flush_done_o,
    output logic [PTR_WIDTH:0]    count_o,
    output logic                  buf_wr_en_o,
    output logic [PTR_WIDTH-1:0]  buf_write_ptr_o,
    output logic [DATA_WIDTH-1:0] buf_write_data_o,
    output logic                  buf_rd_en_o,
    output logic [PTR_WIDTH-1:0]  buf_read_ptr_o,
    input  logic                  buf_read_data_valid_i,
    input  logic [DATA_WIDTH-1:0] buf_read_data_i
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [PTR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH:0]   rd_ptr_q, rd_ptr_d;

    logic                 full;
    logic                 empty;
    logic                 run;
    logic                 accept;
    logic                 pop;
    logic                 flush_pop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign full  = (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]) &&
                   (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign run   = (state_q == ST_RUN);

    // Ready is held low while reset is asserted; otherwise it is purely registered state.
    assign in_ready_o = rst_ni && run && !full;
    assign accept     = in_valid_i && in_ready_o;

    assign buf_wr_en_o      = accept;
    assign buf_write_ptr_o  = wr_ptr_q[PTR_WIDTH-1:0];
    assign buf_write_data_o = in_data_i;
    assign buf_read_ptr_o   = rd_ptr_q[PTR_WIDTH-1:0];

    assign flush_pop   = (state_q == ST_FLUSH) && !empty;
    assign buf_rd_en_o = pop || flush_pop;

    assign count_o      = wr_ptr_q - rd_ptr_q;
    assign flush_done_o = (state_q == ST_DONE);

`ifdef SPW_BUFFER_CTRL_OUT_REG_EN
    logic                  oreg_valid_q, oreg_valid_d;
    logic [DATA_WIDTH-1:0] oreg_data_q, oreg_data_d;

    // Pop whenever the output register is free or being drained this cycle.
    assign pop = run && !empty && buf_read_data_valid_i && (!oreg_valid_q || out_ready_i);

    always_comb begin
        oreg_valid_d = oreg_valid_q;
        oreg_data_d  = oreg_data_q;
        if (pop) begin
            oreg_valid_d = 1'b1;
            oreg_data_d  = buf_read_data_i;
        end else if (out_ready_i) begin
            oreg_valid_d = 1'b0;
        end
        // Entering or sitting in a flush discards the held word as well.
        if (!run || flush_i) begin
            oreg_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            oreg_valid_q <= 1'b0;
        end else begin
            oreg_valid_q <= oreg_valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        oreg_data_q <= oreg_data_d;
    end

    assign out_valid_o = oreg_valid_q;
    assign out_data_o  = oreg_data_q;
`else
    assign out_valid_o = run && !empty && buf_read_data_valid_i;
    assign out_data_o  = buf_read_data_i;
    assign pop         = out_valid_o && out_ready_i;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (flush_i) state_d = ST_FLUSH;
            ST_FLUSH: if (empty)   state_d = ST_DONE;
            ST_DONE:               state_d = ST_RUN;
            default:               state_d = ST_RUN;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{PTR_WIDTH{1'b0}}, accept};
        rd_ptr_d = rd_ptr_q + {{PTR_WIDTH{1'b0}}, buf_rd_en_o};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_RUN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

`ifndef SYNTHESIS
    // A held slot must always present valid data from the buffer.
    a_read_valid_when_nonempty: assert property (
        @(posedge clk_i) disable iff (!rst_ni) !empty |-> buf_read_data_valid_i
    );
`endif

endmodule

// File: tb/tb_spw_buffer_ctrl.sv
// Directed bench for spw_buffer_ctrl with a behavioural spw_buffer model on the buffer ports.
module tb_spw_buffer_ctrl;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         flush;
    logic         flush_done;
    logic [3:0]   count;
    logic         wr_en;
    logic [2:0]   wr_ptr;
    logic [127:0] wr_data;
    logic         rd_en;
    logic [2:0]   rd_ptr;
    logic         rd_dv;
    logic [127:0] rd_data;

    logic [127:0] mem [8];
    logic [7:0]   vbits;

    int n_checks = 0;
    int n_errors = 0;

    spw_buffer_ctrl #(.PTR_WIDTH(3), .DATA_WIDTH(128)) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .in_valid_i            (in_valid),
        .in_ready_o            (in_ready),
        .in_data_i             (in_data),
        .out_valid_o           (out_valid),
        .out_ready_i           (out_ready),
        .out_data_o            (out_data),
        .flush_i               (flush),
        .flush_done_o          (flush_done),
        .count_o               (count),
        .buf_wr_en_o           (wr_en),
        .buf_write_ptr_o       (wr_ptr),
        .buf_write_data_o      (wr_data),
        .buf_rd_en_o           (rd_en),
        .buf_read_ptr_o        (rd_ptr),
        .buf_read_data_valid_i (rd_dv),
        .buf_read_data_i       (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer model: synchronous write, combinational read, valid bit per slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vbits <= '0;
        end else begin
            if (wr_en) vbits[wr_ptr] <= 1'b1;
            if (rd_en) vbits[rd_ptr] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_dv   = vbits[rd_ptr];
    assign rd_data = mem[rd_ptr];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        @(negedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_flush_done", 128'(flush_done), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

`ifdef SPW_BUFFER_CTRL_OUT_REG_EN
        // Single push: visible two cycles later through the output register.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 128'h66;
        #1;
        chk("oreg_n0_valid", 128'(out_valid), 128'(0));
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("oreg_n1_valid", 128'(out_valid), 128'(0));
        chk("oreg_n1_count", 128'(count), 128'(1));
        @(negedge clk);
        #1;
        chk("oreg_n2_valid", 128'(out_valid), 128'(1));
        chk("oreg_n2_data", out_data, 128'h66);
        chk("oreg_n2_count", 128'(count), 128'(0));
        @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            in_valid = (k < 10);
            in_data  = 128'(8'hE0 + k);
            #1;
            if (k >= 2) begin
                chk("oreg_stream_valid", 128'(out_valid), 128'(1));
                chk("oreg_stream_data", out_data, 128'(8'hE0 + k - 2));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
`else
        // Fill all eight slots with downstream stalled.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 128'(8'hA0 + i);
            #1;
            chk("fill_ready", 128'(in_ready), 128'(1));
            chk("fill_wr_en", 128'(wr_en), 128'(1));
            chk("fill_slot", 128'(wr_ptr), 128'(i));
            chk("fill_count", 128'(count), 128'(i));
            @(negedge clk);
        end
        in_data = 128'hFF;
        #1;
        chk("full_ready", 128'(in_ready), 128'(0));
        chk("full_wr_en", 128'(wr_en), 128'(0));
        chk("full_count", 128'(count), 128'(8));
        in_valid = 1'b0;

        // Drain in order.
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("drain_valid", 128'(out_valid), 128'(1));
            chk("drain_data", out_data, 128'(8'hA0 + i));
            chk("drain_rd_en", 128'(rd_en), 128'(1));
            chk("drain_slot", 128'(rd_ptr), 128'(i));
            chk("drain_count", 128'(count), 128'(8 - i));
            @(negedge clk);
        end
        #1;
        chk("drained_valid", 128'(out_valid), 128'(0));
        chk("drained_count", 128'(count), 128'(0));
        chk("drained_rd_en", 128'(rd_en), 128'(0));

        // Streaming push+pop across the slot wrap.
        @(negedge clk);
        for (int k = 0; k < 21; k++) begin
            in_valid = (k < 20);
            in_data  = 128'(8'hC0 + k);
            #1;
            if (k < 20) chk("stream_slot", 128'(wr_ptr), 128'(k % 8));
            if (k == 0) begin
                chk("stream_first_valid", 128'(out_valid), 128'(0));
                chk("stream_first_count", 128'(count), 128'(0));
            end else begin
                chk("stream_valid", 128'(out_valid), 128'(1));
                chk("stream_data", out_data, 128'(8'hC0 + k - 1));
                chk("stream_count", 128'(count), 128'(1));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        chk("stream_end_count", 128'(count), 128'(0));
        chk("stream_end_valid", 128'(out_valid), 128'(0));

        // Flush five held words.
        out_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 128'(8'hD0 + i);
            #1;
            chk("pre_flush_ready", 128'(in_ready), 128'(1));
            @(negedge clk);
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        #1;
        chk("pre_flush_count", 128'(count), 128'(5));
        @(negedge clk);
        flush = 1'b0;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk("flush_ready", 128'(in_ready), 128'(0));
            chk("flush_out_valid", 128'(out_valid), 128'(0));
            chk("flush_rd_en", 128'(rd_en), 128'(1));
            chk("flush_count", 128'(count), 128'(5 - j));
            chk("flush_done_early", 128'(flush_done), 128'(0));
            @(negedge clk);
        end
        #1;
        chk("flush_empty_rd_en", 128'(rd_en), 128'(0));
        chk("flush_empty_done", 128'(flush_done), 128'(0));
        chk("flush_empty_count", 128'(count), 128'(0));
        @(negedge clk);
        #1;
        chk("flush_done_pulse", 128'(flush_done), 128'(1));
        chk("flush_done_ready", 128'(in_ready), 128'(0));
        @(negedge clk);
        #1;
        chk("flush_after_done", 128'(flush_done), 128'(0));
        chk("flush_run_ready", 128'(in_ready), 128'(1));

        // Flush with nothing buffered: pulse in the second cycle.
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("eflush_c1_done", 128'(flush_done), 128'(0));
        chk("eflush_c1_ready", 128'(in_ready), 128'(0));
        @(negedge clk);
        #1;
        chk("eflush_c2_done", 128'(flush_done), 128'(1));
        @(negedge clk);
        #1;
        chk("eflush_c3_done", 128'(flush_done), 128'(0));
        chk("eflush_c3_ready", 128'(in_ready), 128'(1));

        // Reset dropped mid-burst.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 128'(8'h11 * (i + 1));
            @(negedge clk);
        end
        in_data = 128'h44;
        rst_n   = 1'b0;
        #1;
        chk("mid_rst_ready", 128'(in_ready), 128'(0));
        chk("mid_rst_wr_en", 128'(wr_en), 128'(0));
        chk("mid_rst_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_count", 128'(count), 128'(0));
        @(negedge clk);
        rst_n   = 1'b1;
        in_data = 128'h55;
        #1;
        chk("post_rst_wr_en", 128'(wr_en), 128'(1));
        chk("post_rst_slot", 128'(wr_ptr), 128'(0));
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post_rst_out_valid", 128'(out_valid), 128'(1));
        chk("post_rst_out_data", out_data, 128'h55);
        chk("post_rst_rd_slot", 128'(rd_ptr), 128'(0));
        @(negedge clk);
        #1;
        chk("post_rst_end_valid", 128'(out_valid), 128'(0));
        chk("post_rst_end_count", 128'(count), 128'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
